// File: rtl/hex_updown_counter_pkg.sv
// rtl/hex_updown_counter_pkg.sv - shared segment constants and glyph lookup for hex_updown_counter
package hex_updown_counter_pkg;

  localparam int SEG_W = 7;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g; index 15 first
  localparam logic [15:0][SEG_W-1:0] GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [SEG_W-1:0] GLYPH_ZERO = 7'b1000000;

  function automatic logic [SEG_W-1:0] glyph(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/hex_updown_counter_hex7seg.sv
// rtl/hex_updown_counter_hex7seg.sv - one nibble to one active-low 7-segment digit
module hex7seg
  import hex_updown_counter_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  // Pure table lookup; no state
  always_comb begin
    seg = glyph(nibble);
  end

endmodule

// File: rtl/hex_updown_counter.sv
// rtl/hex_updown_counter.sv - prescaled up/down modulo counter with tc pulse and hex display decode (option: HEX_UPDOWN_COUNTER_SAT_EN)
module hex_updown_counter
  import hex_updown_counter_pkg::*;
#(
  parameter int                   NIBBLES = 2,
  parameter longint unsigned      MODULUS = 256,
  parameter int                   DIV     = 1
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       up,
  input  logic                       load,
  input  logic [4*NIBBLES-1:0]       load_value,
  output logic [4*NIBBLES-1:0]       count,
  output logic                       tc,
  output logic [SEG_W*NIBBLES-1:0]   hex
);

  localparam int W     = 4 * NIBBLES;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  // One extra bit so MODULUS = 2^W is representable in the compares
  localparam logic [W:0]       MOD_EXT  = MODULUS[W:0];
  localparam logic [W:0]       MAX_EXT  = MOD_EXT - 1'b1;
  localparam logic [W-1:0]     MAX_CNT  = MAX_EXT[W-1:0];
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [W-1:0]     count_nxt;
  logic             tc_nxt;
  logic [W:0]       cnt_ext;
  logic [W:0]       load_ext;

  assign cnt_ext  = {1'b0, count};
  assign load_ext = {1'b0, load_value};

  // Next-state: load beats step, step only when the prescaler rolls over
  always_comb begin
    count_nxt = count;
    div_nxt   = div_cnt;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = (load_ext >= MOD_EXT) ? MAX_CNT : load_value;
      div_nxt   = '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt = '0;
        if (up) begin
          if (cnt_ext == MAX_EXT) begin
            tc_nxt = 1'b1;
`ifdef HEX_UPDOWN_COUNTER_SAT_EN
            count_nxt = count;
`else
            count_nxt = '0;
`endif
          end else begin
            count_nxt = count + W'(1);
          end
        end else begin
          if (count == '0) begin
            tc_nxt = 1'b1;
`ifdef HEX_UPDOWN_COUNTER_SAT_EN
            count_nxt = count;
`else
            count_nxt = MAX_CNT;
`endif
          end else begin
            count_nxt = count - W'(1);
          end
        end
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end
  end

  // State register; clear acts immediately regardless of clock
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count   <= '0;
      div_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      count   <= count_nxt;
      div_cnt <= div_nxt;
      tc      <= tc_nxt;
    end
  end

  // One decoder per digit, straight off the registered count
  generate
    for (genvar i = 0; i < NIBBLES; i++) begin : g_digit
      hex7seg u_seg (
        .nibble (count[4*i+3:4*i]),
        .seg    (hex[SEG_W*i+SEG_W-1:SEG_W*i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_hex_updown_counter.sv
// tb/tb_hex_updown_counter.sv - directed self-checking bench for hex_updown_counter
module tb_hex_updown_counter;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic       up;
  logic       load;
  logic [7:0] load_value;

  logic [7:0]  count_a, count_m, count_p;
  logic [3:0]  count_t;
  logic        tc_a, tc_m, tc_p, tc_t;
  logic [13:0] hex_a, hex_m, hex_p;
  logic [6:0]  hex_t;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hex_updown_counter #(.NIBBLES(2), .MODULUS(256), .DIV(1)) u_a (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_a), .tc(tc_a), .hex(hex_a));

  hex_updown_counter #(.NIBBLES(2), .MODULUS(10), .DIV(1)) u_m (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_m), .tc(tc_m), .hex(hex_m));

  hex_updown_counter #(.NIBBLES(2), .MODULUS(256), .DIV(4)) u_p (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_p), .tc(tc_p), .hex(hex_p));

  hex_updown_counter #(.NIBBLES(1), .MODULUS(2), .DIV(1)) u_t (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value[3:0]), .count(count_t), .tc(tc_t), .hex(hex_t));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 8'h00;
    #3;
    chk("rst_count", 32'(count_a), 32'h00);
    chk("rst_tc", 32'(tc_a), 32'h0);
    chk("rst_hex", 32'(hex_a), 32'h2040);
    cyc(); cyc();
    clear = 1'b0;

    // Asynchronous clear mid-count
    load = 1'b1; load_value = 8'h5A;
    cyc();
    load = 1'b0;
    chk("load_5a", 32'(count_a), 32'h5A);
    #2 clear = 1'b1;
    #1;
    chk("aclr_count", 32'(count_a), 32'h00);
    chk("aclr_tc", 32'(tc_a), 32'h0);
    chk("aclr_hex", 32'(hex_a), 32'h2040);
    clear = 1'b0;

    // Wrap up from 0xFE
    load = 1'b1; load_value = 8'hFE;
    cyc();
    chk("wrap_ld", 32'(count_a), 32'hFE);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    cyc();
    chk("wrap_ff", 32'(count_a), 32'hFF);
    chk("wrap_ff_tc", 32'(tc_a), 32'h0);
    cyc();
    chk("wrap_00", 32'(count_a), 32'h00);
    chk("wrap_00_tc", 32'(tc_a), 32'h1);
    cyc();
    chk("wrap_01", 32'(count_a), 32'h01);
    chk("wrap_01_tc", 32'(tc_a), 32'h0);
    enable = 1'b0;

    // Modulus 10 counting down from 0
    load = 1'b1; load_value = 8'h00;
    cyc();
    chk("mod_ld0", 32'(count_m), 32'h00);
    load = 1'b0; enable = 1'b1; up = 1'b0;
    cyc();
    enable = 1'b0;
    chk("mod_down", 32'(count_m), 32'h09);
    chk("mod_down_tc", 32'(tc_m), 32'h1);
    chk("mod_hex", 32'(hex_m), 32'h2010);
    load = 1'b1; load_value = 8'h0C;
    cyc();
    load = 1'b0;
    chk("mod_clamp", 32'(count_m), 32'h09);
    chk("mod_clamp_tc", 32'(tc_m), 32'h0);

    // Back-to-back wraps with MODULUS=2
    load = 1'b1; load_value = 8'h01;
    cyc();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    cyc();
`ifdef HEX_UPDOWN_COUNTER_SAT_EN
    chk("m2_up", 32'(count_t), 32'h1);
    chk("m2_up_tc", 32'(tc_t), 32'h1);
    up = 1'b0;
    cyc();
    chk("m2_dn", 32'(count_t), 32'h0);
    chk("m2_dn_tc", 32'(tc_t), 32'h0);
`else
    chk("m2_up", 32'(count_t), 32'h0);
    chk("m2_up_tc", 32'(tc_t), 32'h1);
    up = 1'b0;
    cyc();
    chk("m2_dn", 32'(count_t), 32'h1);
    chk("m2_dn_tc", 32'(tc_t), 32'h1);
    chk("m2_hex", 32'(hex_t), 32'h79);
`endif
    enable = 1'b0; up = 1'b1;

    // Prescaler DIV=4 with enable pattern 1,1,0,1,1
    load = 1'b1; load_value = 8'h00;
    cyc();
    load = 1'b0;
    enable = 1'b1; cyc(); chk("pre_c1", 32'(count_p), 32'h00);
    enable = 1'b1; cyc(); chk("pre_c2", 32'(count_p), 32'h00);
    enable = 1'b0; cyc(); chk("pre_c3", 32'(count_p), 32'h00);
    enable = 1'b1; cyc(); chk("pre_c4", 32'(count_p), 32'h00);
    enable = 1'b1; cyc(); chk("pre_c5", 32'(count_p), 32'h01);
    cyc(); cyc();
    chk("pre_mid", 32'(count_p), 32'h01);
    load = 1'b1; load_value = 8'h10;
    cyc();
    load = 1'b0;
    chk("pre_ld", 32'(count_p), 32'h10);
    cyc(); cyc(); cyc();
    chk("pre_restart3", 32'(count_p), 32'h10);
    cyc();
    chk("pre_restart4", 32'(count_p), 32'h11);

    // Load beats a due step
    cyc(); cyc(); cyc();
    load = 1'b1; load_value = 8'h33;
    cyc();
    load = 1'b0;
    chk("prio_p", 32'(count_p), 32'h33);
    chk("prio_p_tc", 32'(tc_p), 32'h0);
    chk("prio_a", 32'(count_a), 32'h33);
    chk("prio_a_tc", 32'(tc_a), 32'h0);
    enable = 1'b0;

    // Up steps at top of range
    load = 1'b1; load_value = 8'hFF;
    cyc();
    load = 1'b0; enable = 1'b1; up = 1'b1;
`ifdef HEX_UPDOWN_COUNTER_SAT_EN
    cyc(); chk("sat_s1", 32'(count_a), 32'hFF); chk("sat_s1_tc", 32'(tc_a), 32'h1);
    cyc(); chk("sat_s2", 32'(count_a), 32'hFF); chk("sat_s2_tc", 32'(tc_a), 32'h1);
    cyc(); chk("sat_s3", 32'(count_a), 32'hFF); chk("sat_s3_tc", 32'(tc_a), 32'h1);
`else
    cyc(); chk("top_s1", 32'(count_a), 32'h00); chk("top_s1_tc", 32'(tc_a), 32'h1);
    cyc(); chk("top_s2", 32'(count_a), 32'h01); chk("top_s2_tc", 32'(tc_a), 32'h0);
    cyc(); chk("top_s3", 32'(count_a), 32'h02); chk("top_s3_hex", 32'(hex_a), 32'h2024);
`endif
    enable = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
